// File: rtl/audio_ctrl_pkg.sv
// Shared command codes and fade sequencer state encoding
// for the audio mode switch.
package audio_ctrl_pkg;

  localparam logic [3:0] CMD_MODE    = 4'b0010;
  localparam logic [3:0] CMD_ETH_ON  = 4'b0100;
  localparam logic [3:0] CMD_ETH_OFF = 4'b1000;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FADE_OUT,
    ST_SWITCH,
    ST_FADE_IN
  } state_t;

endpackage

// File: rtl/audio_gain_stage.sv
// Registered gain scaler: (sample * gain) >>> RAMP_BITS,
// captured on each sample strobe.
module audio_gain_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int RAMP_BITS  = 6
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         sample_stb,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic [RAMP_BITS:0]           gain,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_out_vld
);

  localparam int PW = DATA_WIDTH + RAMP_BITS + 2;

  logic signed [PW-1:0]         prod;
  logic signed [DATA_WIDTH-1:0] scaled;

  // gain is unsigned, so widen it with a zero msb before the signed multiply
  assign prod   = sample * $signed({1'b0, gain});
  assign scaled = DATA_WIDTH'(prod >>> RAMP_BITS);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else begin
      data_out_vld <= sample_stb;
      if (sample_stb) data_out <= scaled;
    end
  end

endmodule

// File: rtl/audio_mode_switch.sv
// Command decoder, fade sequencer and path mux; switches
// processing paths with a fade-out / fade-in gain ramp.
module audio_mode_switch
  import audio_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_MODES  = 4,
  parameter int RAMP_BITS  = 6
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst,
  input  logic                             cmd_valid,
  input  logic [3:0]                       ctrl_cmd,
  input  logic [3:0]                       value_cmd,
  input  logic                             sample_stb,
  input  logic [NUM_MODES*DATA_WIDTH-1:0]  path_data,
  output logic signed [DATA_WIDTH-1:0]     data_out,
  output logic                             data_out_vld,
  output logic [NUM_MODES-1:0]             mode_enable,
  output logic                             eth_enable,
  output logic                             busy,
  output logic                             cmd_err
);

  localparam logic [RAMP_BITS:0] FULL = {1'b1, {RAMP_BITS{1'b0}}};
  localparam logic [RAMP_BITS:0] ZERO = '0;
  localparam logic [4:0]         NM   = 5'(NUM_MODES);

  state_t                       state, nxt;
  logic [3:0]                   active, pend;
  logic                         pend_flag;
  logic [RAMP_BITS:0]           gain;
  logic signed [DATA_WIDTH-1:0] sample;
  logic                         mode_ok, same_idle;

  assign mode_ok   = {1'b0, value_cmd} < NM;
  assign same_idle = (state == ST_RUN) && (value_cmd == active);
  assign busy      = (state != ST_RUN);

  always_comb begin
    sample      = '0;
    mode_enable = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      mode_enable[k] = (active == 4'(k));
      if (active == 4'(k))
        sample = path_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= ST_RUN;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_RUN:      if (pend_flag && pend != active) nxt = ST_FADE_OUT;
      ST_FADE_OUT: if (gain == ZERO) nxt = ST_SWITCH;
      ST_SWITCH:   nxt = ST_FADE_IN;
      ST_FADE_IN:  if (gain == FULL) nxt = ST_RUN;
      default:     nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      active     <= '0;
      pend       <= '0;
      pend_flag  <= 1'b0;
      gain       <= FULL;
      eth_enable <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (state == ST_FADE_OUT && sample_stb && gain != ZERO)
        gain <= gain - 1'b1;
      if (state == ST_FADE_IN && sample_stb && gain != FULL)
        gain <= gain + 1'b1;
      if (state == ST_SWITCH) begin
        active    <= pend;
        pend_flag <= 1'b0;
      end
      if (state == ST_RUN && pend_flag && pend == active)
        pend_flag <= 1'b0;
      // a fresh request wins over the flag clears above
      if (cmd_valid) begin
        unique case (1'b1)
          ctrl_cmd == CMD_MODE: begin
            if (!mode_ok) begin
              cmd_err <= 1'b1;
            end else if (!same_idle) begin
              pend      <= value_cmd;
              pend_flag <= 1'b1;
            end
          end
          ctrl_cmd == CMD_ETH_ON:  eth_enable <= 1'b1;
          ctrl_cmd == CMD_ETH_OFF: eth_enable <= 1'b0;
          default:                 cmd_err    <= 1'b1;
        endcase
      end
    end
  end

  audio_gain_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .RAMP_BITS (RAMP_BITS)
  ) u_gain (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .sample_stb  (sample_stb),
    .sample      (sample),
    .gain        (gain),
    .data_out    (data_out),
    .data_out_vld(data_out_vld)
  );

endmodule

// File: tb/tb_audio_mode_switch.sv
// Directed bench for audio_mode_switch: reset, fades,
// command errors, last-wins requests and mid-fade reset.
module tb_audio_mode_switch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic [3:0]  ctrl_cmd;
  logic [3:0]  value_cmd;
  logic        sample_stb;
  logic [63:0] path_data;
  logic signed [15:0] data_out;
  logic        data_out_vld;
  logic [3:0]  mode_enable;
  logic        eth_enable;
  logic        busy;
  logic        cmd_err;

  int tests = 0;
  int fails = 0;
  logic saw1;

  always #5 sys_clk = ~sys_clk;

  audio_mode_switch dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .cmd_valid   (cmd_valid),
    .ctrl_cmd    (ctrl_cmd),
    .value_cmd   (value_cmd),
    .sample_stb  (sample_stb),
    .path_data   (path_data),
    .data_out    (data_out),
    .data_out_vld(data_out_vld),
    .mode_enable (mode_enable),
    .eth_enable  (eth_enable),
    .busy        (busy),
    .cmd_err     (cmd_err)
  );

  task automatic check(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [3:0] v);
    cmd_valid = 1'b1;
    ctrl_cmd  = c;
    value_cmd = v;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic stb();
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
  endtask

  task automatic reset_vals(input string tag);
    check({tag, "_dout"}, data_out, 0);
    check({tag, "_vld"}, 32'(data_out_vld), 0);
    check({tag, "_mode"}, 32'(mode_enable), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_eth"}, 32'(eth_enable), 0);
    check({tag, "_err"}, 32'(cmd_err), 0);
  endtask

  initial begin
    sys_rst    = 1'b0;
    cmd_valid  = 1'b0;
    ctrl_cmd   = '0;
    value_cmd  = '0;
    sample_stb = 1'b0;
    path_data  = {16'd3000, 16'h8000, 16'd111, 16'd1000};
    #12;
    reset_vals("rst");
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    tick();

    stb();
    check("run_dout", data_out, 1000);
    check("run_vld", 32'(data_out_vld), 1);
    tick();
    check("run_vld_drop", 32'(data_out_vld), 0);
    check("run_mode", 32'(mode_enable), 1);
    check("run_busy", 32'(busy), 0);

    cmd(4'b0010, 4'b0111);
    check("bad_mode_err", 32'(cmd_err), 1);
    check("bad_mode_en", 32'(mode_enable), 1);
    check("bad_mode_busy", 32'(busy), 0);
    tick();
    check("bad_mode_err1", 32'(cmd_err), 0);
    check("bad_mode_busy1", 32'(busy), 0);
    cmd(4'b0001, 4'b0000);
    check("bad_ctrl_err", 32'(cmd_err), 1);

    cmd(4'b0100, 4'b0000);
    check("eth_on", 32'(eth_enable), 1);
    cmd(4'b1000, 4'b0000);
    check("eth_off", 32'(eth_enable), 0);

    // switch to path 2 with 64-cycle sample spacing
    cmd(4'b0010, 4'b0010);
    tick();
    check("fo_busy", 32'(busy), 1);
    for (int i = 0; i < 64; i++) begin
      stb();
      check($sformatf("fo_%0d", i), data_out, (1000 * (64 - i)) / 64);
      repeat (63) tick();
    end
    check("sw_mode", 32'(mode_enable), 4);
    check("sw_busy", 32'(busy), 1);
    for (int j = 0; j < 64; j++) begin
      if (j == 10) begin
        cmd_valid = 1'b1;
        ctrl_cmd  = 4'b0100;
      end
      stb();
      cmd_valid = 1'b0;
      check($sformatf("fi_%0d", j), data_out, -512 * j);
      if (j == 10) check("fi_eth", 32'(eth_enable), 1);
      repeat (63) tick();
    end
    check("fi_done_busy", 32'(busy), 0);
    stb();
    check("full_neg", data_out, -32768);

    // mode 1 then mode 3 while fading: only mode 3 is taken
    saw1 = 1'b0;
    cmd(4'b0010, 4'b0001);
    tick();
    for (int i = 0; i < 64; i++) begin
      if (i == 5) begin
        cmd_valid = 1'b1;
        ctrl_cmd  = 4'b0010;
        value_cmd = 4'b0011;
      end
      stb();
      cmd_valid = 1'b0;
      if (mode_enable == 4'b0010) saw1 = 1'b1;
      tick();
    end
    repeat (4) tick();
    check("lw_mode", 32'(mode_enable), 8);
    for (int j = 0; j < 64; j++) begin
      stb();
      if (mode_enable == 4'b0010) saw1 = 1'b1;
      check($sformatf("lw_fi_%0d", j), data_out, (3000 * j) / 64);
      tick();
    end
    repeat (3) tick();
    check("lw_no_mode1", 32'(saw1), 0);
    check("lw_busy", 32'(busy), 0);
    stb();
    check("lw_full", data_out, 3000);

    cmd(4'b0010, 4'b0011);
    check("same_err", 32'(cmd_err), 0);
    tick();
    check("same_busy", 32'(busy), 0);

    // reset during fade-out at gain 20
    cmd(4'b0010, 4'b0000);
    tick();
    for (int i = 0; i < 44; i++) begin
      stb();
      tick();
    end
    check("mid_dout", data_out, 984);
    check("mid_eth", 32'(eth_enable), 1);
    check("mid_busy", 32'(busy), 1);
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    #2;
    reset_vals("arst");
    @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    tick();
    stb();
    check("post_rst_dout", data_out, 1000);
    check("post_rst_mode", 32'(mode_enable), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
